lcg_stim_gen: RTL

Synthesizable, parametrised stimulus engine that produces the deterministic LCG input vectors our fuzz benches drive into `top.in_flat`, so stimulus can live in RTL (emulation/FPGA runs) instead of testbench procedural code. It generates an initial vector plus a programmable number of further vectors, presented over a valid/ready handshake, in one of four stimulus modes. It sits between the run controller and the DUT `in_flat` port.

---
 rtl/lcg_stim_if.sv | 28 ++
 rtl/lcg_stim_gen.sv | 117 +++++++++++
 2 files changed

// File: rtl/lcg_stim_if.sv
// lcg_stim_if: control and stimulus bundle between run controller/DUT and lcg_stim_gen.
//   master (generator side): takes start/mode/cycles/seed_load/seed_in/ready,
//   drives stim_out/stim_valid/cyc_count/busy/done.
//   slave (controller/consumer side): the mirror image.
interface lcg_stim_if #(
  parameter int OUT_W = 136,
  parameter int CYC_W = 32
);
  logic             start;
  logic [1:0]       mode;
  logic [CYC_W-1:0] cycles;
  logic             seed_load;
  logic [31:0]      seed_in;
  logic             ready;
  logic [OUT_W-1:0] stim_out;
  logic             stim_valid;
  logic [CYC_W-1:0] cyc_count;
  logic             busy;
  logic             done;
  modport master (
    input  start, mode, cycles, seed_load, seed_in, ready,
    output stim_out, stim_valid, cyc_count, busy, done
  );
  modport slave (
    output start, mode, cycles, seed_load, seed_in, ready,
    input  stim_out, stim_valid, cyc_count, busy, done
  );
endinterface

// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: LCG-based stimulus engine producing cycles+1 vectors over valid/ready.
//   clk, rst_n (async, active-low); bus (lcg_stim_if.master): start/mode/cycles/
//   seed_load/seed_in/ready in, stim_out/stim_valid/cyc_count/busy/done out.
//   Optional macro LCG_STIM_TRACE_EN: prints CYCLE=<n> IN=<hex> on each handshake (sim only).
module lcg_stim_gen #(
  parameter int          OUT_W = 136,
  parameter logic [31:0] SEED  = 32'd1911213317,
  parameter int          CYC_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  lcg_stim_if.master  bus
);
  localparam int NW = (OUT_W + 31) / 32;
  localparam int WW = NW > 1 ? $clog2(NW) : 1;
  localparam int PW = OUT_W > 1 ? $clog2(OUT_W) : 1;
  typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] lcg, lcg_nx, lcg_step;
  logic [OUT_W-1:0] stim, stim_nx, tgt;
  logic valid, valid_nx, busy, busy_nx, done, done_nx;
  logic [CYC_W-1:0] cnt, cnt_nx, cyc_q, cyc_nx;
  logic [1:0] mode_q, mode_nx;
  logic [WW-1:0] widx, widx_nx;
  logic [PW-1:0] wpos, wpos_nx;
  logic rnd_fill, wr_en;
  assign lcg_step = lcg * 32'h41C64E6D + 32'h3039;
  // cnt doubles as the index of the vector being built: it equals the number already accepted
  assign tgt = mode_q == 2'd1 ? OUT_W'(1) << wpos : OUT_W'(cnt);
  // hold mode draws random words only for vector 0 and then leaves stim untouched
  assign rnd_fill = mode_q == 2'd0 || (mode_q == 2'd2 && cnt == '0);
  assign wr_en = mode_q != 2'd2 || rnd_fill;
  always_comb begin
    state_nx = state;
    lcg_nx = lcg;
    stim_nx = stim;
    valid_nx = valid;
    busy_nx = busy;
    done_nx = done;
    cnt_nx = cnt;
    cyc_nx = cyc_q;
    mode_nx = mode_q;
    widx_nx = widx;
    wpos_nx = wpos;
    if (state == IDLE || state == DONE) begin
      if (bus.seed_load) lcg_nx = bus.seed_in;
      if (bus.start) begin
        state_nx = FILL;
        busy_nx = 1'b1;
        done_nx = 1'b0;
        cnt_nx = '0;
        cyc_nx = bus.cycles;
        mode_nx = bus.mode;
        widx_nx = '0;
        wpos_nx = '0;
      end
    end else if (state == FILL) begin
      if (rnd_fill) lcg_nx = lcg_step;
      if (wr_en)
        for (int b = 0; b < OUT_W; b++)
          if (b / 32 == int'(widx)) stim_nx[b] = rnd_fill ? lcg_step[b % 32] : tgt[b];
      widx_nx = widx + 1'b1;
      if (int'(widx) == NW - 1) begin
        state_nx = PRESENT;
        valid_nx = 1'b1;
        widx_nx = '0;
      end
    end else if (bus.ready) begin
      valid_nx = 1'b0;
      cnt_nx = &cnt ? cnt : cnt + 1'b1;
      if (cnt == cyc_q) begin
        state_nx = DONE;
        busy_nx = 1'b0;
        done_nx = 1'b1;
      end else begin
        state_nx = FILL;
        wpos_nx = int'(wpos) == OUT_W - 1 ? '0 : wpos + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lcg <= SEED;
      stim <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      cyc_q <= '0;
      mode_q <= '0;
      widx <= '0;
      wpos <= '0;
    end else begin
      state <= state_nx;
      lcg <= lcg_nx;
      stim <= stim_nx;
      valid <= valid_nx;
      busy <= busy_nx;
      done <= done_nx;
      cnt <= cnt_nx;
      cyc_q <= cyc_nx;
      mode_q <= mode_nx;
      widx <= widx_nx;
      wpos <= wpos_nx;
    end
  end
`ifdef LCG_STIM_TRACE_EN
  always_ff @(posedge clk)
    if (rst_n && state == PRESENT && bus.ready) $write("CYCLE=%0d IN=%h\n", cnt, stim);
`endif
  assign bus.stim_out = stim;
  assign bus.stim_valid = valid;
  assign bus.cyc_count = cnt;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
